// File: rtl/golden_nonce_reporter.sv
// golden_nonce_reporter
//   Buffers golden nonces from the miner in a small FIFO and sends each one
//   to the UART transmitter as a 5-byte frame on a valid/ready byte stream:
//   SYNC_BYTE followed by the four nonce bytes. All logic is in hash_clk.
//
// Ports
//   hash_clk          clock, rising edge
//   reset             synchronous, active-high
//   new_golden_nonce  single-cycle strobe qualifying golden_nonce
//   golden_nonce      32-bit nonce
//   tx_data/tx_valid  byte stream to the transmitter
//   tx_ready          transmitter accepts when tx_valid & tx_ready
//   fifo_count        entries currently stored (0..DEPTH)
//   overflow          sticky: a nonce was dropped on a full FIFO
//   drop_count        dropped-nonce counter, saturating at 8'hFF
//   busy              FIFO non-empty or a frame in progress
module golden_nonce_reporter #(
  parameter int          DEPTH_LOG2 = 2,
  parameter bit          BYTESWAP   = 1'b0,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                  hash_clk,
  input  logic                  reset,
  input  logic                  new_golden_nonce,
  input  logic [31:0]           golden_nonce,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow,
  output logic [7:0]            drop_count,
  output logic                  busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic {IDLE, SEND} state_e;

  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            drop_q, drop_d;
  state_e                state_q, state_d;
  logic [31:0]           shreg_q, shreg_d;
  logic [2:0]            idx_q, idx_d;

  logic full, pop, push, drop;

  function automatic logic [31:0] bswap(input logic [31:0] n);
    return {n[7:0], n[15:8], n[23:16], n[31:24]};
  endfunction

  assign full = (count_q == FULL);
  // A pop on the same edge frees a slot, so a strobe at full is still taken.
  assign push = new_golden_nonce & (~full | pop);
  assign drop = new_golden_nonce & full & ~pop;

  // Frame FSM. The nonce is pre-ordered into the shift register at pop time so
  // the send path always emits the top byte and shifts left on acceptance.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    idx_d    = idx_q;
    pop      = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shreg_d = BYTESWAP ? bswap(mem_q[rd_ptr_q]) : mem_q[rd_ptr_q];
          idx_d   = 3'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = (idx_q == 3'd0) ? SYNC_BYTE : shreg_q[31:24];
        if (tx_ready) begin
          if (idx_q != 3'd0) shreg_d = shreg_q << 8;
          if (idx_q == 3'd4) state_d = IDLE;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      drop_q   <= 8'h00;
      state_q  <= IDLE;
      shreg_q  <= '0;
      idx_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  // Storage needs no reset; only entries below count_q are ever read.
  always_ff @(posedge hash_clk) begin
    if (!reset && push) mem_q[wr_ptr_q] <= golden_nonce;
  end

  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;
  assign busy       = (count_q != '0) | (state_q == SEND);

endmodule

// File: tb/tb_golden_nonce_reporter.sv
module tb_golden_nonce_reporter;
  logic        hash_clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_golden_nonce = 1'b0;
  logic [31:0] golden_nonce = '0;
  logic        tx_ready = 1'b0;

  logic [7:0] tx_data0, tx_data1, drop_count0, drop_count1;
  logic       tx_valid0, tx_valid1, overflow0, overflow1, busy0, busy1;
  logic [2:0] fifo_count0, fifo_count1;

  int passed = 0;
  int total  = 0;

  always #5 hash_clk = ~hash_clk;

  golden_nonce_reporter #(.DEPTH_LOG2(2), .BYTESWAP(1'b0), .SYNC_BYTE(8'hA5)) dut0 (
    .hash_clk(hash_clk), .reset(reset), .new_golden_nonce(new_golden_nonce),
    .golden_nonce(golden_nonce), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready), .fifo_count(fifo_count0), .overflow(overflow0),
    .drop_count(drop_count0), .busy(busy0));

  golden_nonce_reporter #(.DEPTH_LOG2(2), .BYTESWAP(1'b1), .SYNC_BYTE(8'hA5)) dut1 (
    .hash_clk(hash_clk), .reset(reset), .new_golden_nonce(new_golden_nonce),
    .golden_nonce(golden_nonce), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready), .fifo_count(fifo_count1), .overflow(overflow1),
    .drop_count(drop_count1), .busy(busy1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a queue of stored nonces plus "frame in flight" with
  // bytes remaining. Accepted nonces push their expected bytes to the
  // scoreboards at acceptance time, since frames leave in FIFO order.
  int unsigned m_q[$];
  bit          m_send = 0;
  int          m_left = 0;
  bit          m_ovf = 0;
  int          m_drops = 0;
  logic [7:0]  exp0[$], exp1[$];
  bit          hold_v = 0;
  logic [7:0]  hold0, hold1;

  function automatic void push_frame(input logic [31:0] n);
    exp0.push_back(8'hA5);
    exp1.push_back(8'hA5);
    for (int i = 3; i >= 0; i--) exp0.push_back(n[8*i +: 8]);
    for (int i = 0; i <= 3; i++) exp1.push_back(n[8*i +: 8]);
  endfunction

  // Monitor + model step, sampled mid-cycle on stable signals; models the
  // effect of the coming rising edge.
  always @(negedge hash_clk) begin
    bit pop;
    chk("tx_valid0", tx_valid0, m_send);
    chk("tx_valid1", tx_valid1, m_send);
    chk("fifo_count", fifo_count0, m_q.size());
    chk("overflow", overflow0, m_ovf);
    chk("drop_count", drop_count0, m_drops);
    chk("busy", busy0, (m_q.size() != 0) || m_send);
    chk("dut1_count", {overflow1, drop_count1, fifo_count1, busy1},
        {overflow0, drop_count0, fifo_count0, busy0});
    if (hold_v && tx_valid0) begin
      chk("stable0", tx_data0, hold0);
      chk("stable1", tx_data1, hold1);
    end
    if (tx_valid0 && tx_ready) begin
      if (exp0.size() == 0) chk("unexpected_byte0", tx_data0, 32'hFFFF_FFFF);
      else chk("byte0", tx_data0, exp0.pop_front());
    end
    if (tx_valid1 && tx_ready) begin
      if (exp1.size() == 0) chk("unexpected_byte1", tx_data1, 32'hFFFF_FFFF);
      else chk("byte1", tx_data1, exp1.pop_front());
    end
    hold_v = tx_valid0 && !tx_ready && !reset;
    hold0 = tx_data0;
    hold1 = tx_data1;

    if (reset) begin
      m_q.delete(); m_send = 0; m_left = 0; m_ovf = 0; m_drops = 0;
      exp0.delete(); exp1.delete();
    end else begin
      pop = !m_send && (m_q.size() != 0);
      if (m_send && tx_ready) begin
        m_left--;
        if (m_left == 0) m_send = 0;
      end
      if (new_golden_nonce) begin
        if (m_q.size() < 4 || pop) begin
          m_q.push_back(golden_nonce);
          push_frame(golden_nonce);
        end else begin
          m_ovf = 1;
          if (m_drops < 255) m_drops++;
        end
      end
      if (pop) begin
        void'(m_q.pop_front());
        m_send = 1;
        m_left = 5;
      end
    end
  end

  task automatic step();
    @(posedge hash_clk);
    #1;
  endtask

  task automatic strobe(input logic [31:0] n);
    new_golden_nonce = 1'b1;
    golden_nonce = n;
    step();
    new_golden_nonce = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    tx_ready = 1'b1;
    for (int i = 0; i < 300 && (exp0.size() != 0 || busy0); i++) step();
    step();
    chk(name, exp0.size() + exp1.size(), 0);
  endtask

  initial begin
    bit hit;
    do_reset();

    // Single frame, both byte orders, continuously ready sink
    tx_ready = 1'b1;
    strobe(32'h1DAC2B7C);
    repeat (8) step();
    drain("drain_single");

    // Backpressure: hold ready low after the first valid, then toggle
    do_reset();
    tx_ready = 1'b0;
    strobe(32'h1DAC2B7C);
    for (int i = 0; i < 20 && !tx_valid0; i++) step();
    repeat (10) step();
    for (int i = 0; i < 14; i++) begin tx_ready = ~tx_ready; step(); end
    drain("drain_backpressure");

    // Overflow: nonces 1..6 with the sink stalled
    do_reset();
    tx_ready = 1'b0;
    for (int i = 1; i <= 6; i++) strobe(i);
    @(negedge hash_clk);
    chk("ovf_count", fifo_count0, 4);
    chk("ovf_flag", overflow0, 1);
    chk("ovf_drops", drop_count0, 1);
    drain("drain_overflow");

    // Full FIFO, strobe on the edge of an IDLE pop
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) strobe(32'hA000_0000 + i);
    tx_ready = 1'b1;
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      step();
      if (!tx_valid0 && fifo_count0 == 3'd4) begin
        strobe(32'hCAFE_F00D);
        hit = 1;
      end
    end
    chk("full_pop_hit", hit, 1);
    @(negedge hash_clk);
    chk("full_pop_count", fifo_count0, 4);
    chk("full_pop_ovf", overflow0, 0);
    drain("drain_full_pop");

    // Reset mid-frame during the byte-2 handshake with two entries queued
    do_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) strobe(32'h5500_0000 + i);
    repeat (3) step();
    tx_ready = 1'b1;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge hash_clk);
    chk("rst_valid", tx_valid0, 0);
    chk("rst_count", fifo_count0, 0);
    chk("rst_ovf", overflow0, 0);
    step();
    strobe(32'hDEADBEEF);
    drain("drain_after_reset");

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      new_golden_nonce = ($urandom_range(3) == 0);
      golden_nonce = $urandom;
      tx_ready = ($urandom_range(3) != 0);
      reset = ($urandom_range(199) == 0);
      step();
    end
    new_golden_nonce = 1'b0;
    reset = 1'b0;
    drain("drain_random");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/golden_nonce_reporter.md
Name: golden_nonce_reporter

Overview:
Downstream consumer of fpgaminer_top. It captures each golden_nonce qualified by new_golden_nonce into a small FIFO, so back-to-back hits are never lost while the host link is slow. It serializes each stored nonce as a 5-byte frame on a valid/ready byte stream that feeds the UART transmitter. It runs in the hash_clk domain.

Parameters:
DEPTH_LOG2, 2, FIFO depth = 2**DEPTH_LOG2 entries of 32 bits
BYTESWAP, 0, 0 = nonce bytes sent MSB first; 1 = LSB first (blockchain-explorer byte order)
SYNC_BYTE, 8'hA5, header byte that opens every frame

Ports:
hash_clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-high
new_golden_nonce  input  1  single-cycle strobe from miner
golden_nonce  input  32  nonce, valid when new_golden_nonce=1
tx_data  output  8  byte to transmitter
tx_valid  output  1  tx_data valid
tx_ready  input  1  transmitter accepts byte when tx_valid&tx_ready
fifo_count  output  DEPTH_LOG2+1  entries currently stored
overflow  output  1  sticky: a nonce was dropped because the FIFO was full
drop_count  output  8  dropped-nonce counter, saturates at 8'hFF
busy  output  1  1 when FIFO non-empty or a frame is in progress

Behaviour:
- Reset (sync): FIFO pointers, fifo_count, overflow, drop_count, tx_valid, busy all 0; tx_data 8'h00; FSM to IDLE. Reset mid-frame aborts the frame; the remaining bytes are never sent and tx_valid is 0 in the cycle after the reset edge.
- FIFO write: occurs on the edge where new_golden_nonce=1 and (count<DEPTH or a pop occurs on the same edge). A simultaneous push and pop at full is accepted, and count stays at DEPTH.
- Drop: new_golden_nonce=1 while full with no same-edge pop leaves the FIFO unchanged, sets overflow=1, and increments drop_count (saturating).
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- FSM states: IDLE, SEND.
  - IDLE: if count>0, pop the head into a 32-bit shift register, set byte index=0, and go to SEND. tx_valid=0 in IDLE.
  - SEND: tx_valid=1. tx_data is selected by index: 0 gives SYNC_BYTE; 1..4 give nonce bytes [31:24],[23:16],[15:8],[7:0] (reverse order when BYTESWAP=1).
  - On tx_valid&tx_ready, index increments. After index 4 is accepted, the FSM returns to IDLE.
- Handshake: tx_data is stable while tx_valid&!tx_ready. tx_valid never drops without acceptance (except reset). tx_ready is ignored in IDLE.
- Latency: strobe in cycle N → count=1 in N+1 → pop on edge ending N+1 → tx_valid=1 with SYNC_BYTE in N+2. A continuously ready sink sees 5 consecutive valid cycles.
- Frame spacing: at least one IDLE cycle (tx_valid=0) between frames. A full frame plus gap takes 6 cycles minimum.
- FIFO order is strictly first-in first-out. A new_golden_nonce arriving during SEND is queued and does not disturb the current frame.
- busy = (count!=0) | (state==SEND).

Test Plan:
1. BYTESWAP=0, tx_ready=1, single strobe with nonce 32'h1DAC2B7C → tx bytes A5,1D,AC,2B,7C in cycles N+2..N+6; busy falls in N+7; count returns to 0.
2. BYTESWAP=1, same nonce → A5,7C,2B,AC,1D.
3. tx_ready=0 for 10 cycles after the first valid, then toggled 1/0 → every byte held stable until accepted, no byte duplicated or skipped, and the frame content is still A5,1D,AC,2B,7C.
4. tx_ready=0, 6 strobes of nonces 1..6 with DEPTH_LOG2=2 → after the first is popped the FIFO holds nonces 2..5 (count=4), nonce 6 is dropped, overflow=1, drop_count=1. Releasing tx_ready yields frames for nonces 1,2,3,4,5 in order.
5. Full FIFO with a strobe on the same edge as an IDLE pop → nonce accepted, count stays 4, overflow unchanged.
6. Assert reset during the byte-2 handshake with 2 entries queued → tx_valid=0, count=0, overflow=0 next cycle. A subsequent strobe with 32'hDEADBEEF sends a clean frame A5,DE,AD,BE,EF.
